// File: rtl/clk_div_mon_pkg.sv
// Shared definitions for the divided-clock monitor.
// - mon_state_e : monitor FSM states (IDLE = 0, ARM = 1, MEAS = 2); the same
//                 encoding is used by the divider's own testbench.
// - *_DEF       : default parameter values for a divider with a 53-cycle
//                 pattern of 10 periods (7 x 5 + 3 x 6 clk cycles).
// - ECW         : width of the per-window rising-edge count.
package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } mon_state_e;

  localparam int unsigned WIN_DEF       = 53;
  localparam int unsigned EXP_EDGES_DEF = 10;
  localparam int unsigned MIN_PER_DEF   = 5;
  localparam int unsigned MAX_PER_DEF   = 6;
  localparam int unsigned LOCK_N_DEF    = 4;
  localparam int unsigned TO_DEF        = 15;
  localparam int unsigned PW_DEF        = 8;
  localparam int unsigned WW_DEF        = 9;

  localparam int unsigned ECW = 4;

endpackage

// File: rtl/clk_div_mon_if.sv
// Monitor-side bundle of the divided-clock checker.
// master : the agent driving the divided clock and the monitor controls
//          (div_in, en, clr) and observing the results.
// slave  : the monitor itself.
// Signals:
//   div_in     divided clock, already registered in the clk domain
//   en         monitor enable
//   clr        one-cycle pulse clearing sticky flags, good count and locked
//   rise_pulse one-cycle strobe per rising edge of div_in
//   period     last measured period in clk cycles (PW bits)
//   period_vld one-cycle strobe when period is updated
//   win_done   one-cycle strobe at the end of each window
//   edge_cnt   rising edges in the last completed window
//   per_err    sticky period-out-of-range / timeout flag
//   cnt_err    sticky edge-count mismatch flag
//   locked     enough consecutive clean windows seen
interface clk_div_mon_if
  import clk_div_mon_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
);

  logic           div_in;
  logic           en;
  logic           clr;
  logic           rise_pulse;
  logic [PW-1:0]  period;
  logic           period_vld;
  logic           win_done;
  logic [ECW-1:0] edge_cnt;
  logic           per_err;
  logic           cnt_err;
  logic           locked;

  modport master (
    output div_in, en, clr,
    input  rise_pulse, period, period_vld, win_done, edge_cnt,
           per_err, cnt_err, locked
  );

  modport slave (
    input  div_in, en, clr,
    output rise_pulse, period, period_vld, win_done, edge_cnt,
           per_err, cnt_err, locked
  );

endinterface

// File: rtl/clk_div_mon_edge_det_rise.sv
// Rising-edge detector for a signal that is already in the clk domain.
// Two flops delay the input; rise is high for exactly one cycle, the cycle
// after d1 first captures a 1. Reusable by any stage consuming the divider.
// Ports:
//   clk   in  system clock
//   rstn  in  asynchronous active-low reset
//   din   in  clk-domain signal to watch
//   rise  out one-cycle strobe per 0->1 transition of din
module edge_det_rise (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic d1;
  logic d2;

  // NOTE: flops use non-blocking assignments so d2 takes the old d1, not the
  // value d1 is receiving on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= din;
      d2 <= d1;
    end
  end

  assign rise = d1 & ~d2;

endmodule

// File: rtl/clk_div_mon.sv
// Downstream checker for the fractional clock divider.
// Measures each divided period in clk cycles, counts rising edges per window
// of WIN clk cycles, flags period / edge-count errors and raises locked after
// LOCK_N consecutive clean windows. Pure observer: never drives div_in.
// Ports:
//   clk   in  system clock (the divider's source clock)
//   rstn  in  asynchronous active-low reset
//   bus   slave side of clk_div_mon_if (see the interface for signal list)
module clk_div_mon
  import clk_div_mon_pkg::*;
#(
  parameter int unsigned WIN       = WIN_DEF,
  parameter int unsigned EXP_EDGES = EXP_EDGES_DEF,
  parameter int unsigned MIN_PER   = MIN_PER_DEF,
  parameter int unsigned MAX_PER   = MAX_PER_DEF,
  parameter int unsigned LOCK_N    = LOCK_N_DEF,
  parameter int unsigned TO        = TO_DEF,
  parameter int unsigned PW        = PW_DEF,
  parameter int unsigned WW        = WW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  clk_div_mon_if.slave  bus
);

  localparam int unsigned GW = $clog2(LOCK_N + 1);

  localparam logic [PW-1:0]  TO_V     = PW'(TO);
  localparam logic [PW-1:0]  MIN_V    = PW'(MIN_PER);
  localparam logic [PW-1:0]  MAX_V    = PW'(MAX_PER);
  localparam logic [WW-1:0]  WIN_LAST = WW'(WIN - 1);
  localparam logic [GW-1:0]  LOCK_V   = GW'(LOCK_N);
  localparam logic [ECW:0]   EXP_V    = (ECW + 1)'(EXP_EDGES);
  localparam logic [ECW:0]   ACC_MAX  = {1'b0, {ECW{1'b1}}};

  mon_state_e     state_q, state_d;
  logic [PW-1:0]  per_cnt_q, per_cnt_d;
  logic [WW-1:0]  win_cnt_q, win_cnt_d;
  logic [ECW-1:0] edge_acc_q, edge_acc_d;
  logic [GW-1:0]  good_cnt_q, good_cnt_d;
  logic           win_bad_q, win_bad_d;
  logic [PW-1:0]  period_q, period_d;
  logic [ECW-1:0] edge_cnt_q, edge_cnt_d;
  logic           per_err_q, per_err_d;
  logic           cnt_err_q, cnt_err_d;

  logic           rise;
  logic           period_vld;
  logic           win_done;
  logic           timeout;
  logic           per_bad;
  logic           cnt_bad;
  logic           clean;
  logic [ECW:0]   win_sum;
  logic [ECW-1:0] win_total;

  edge_det_rise u_rise (
    .clk  (clk),
    .rstn (rstn),
    .din  (bus.div_in),
    .rise (rise)
  );

  // Edge count for the window that ends this cycle, including a rise landing
  // on the last cycle; saturates so a runaway input cannot wrap to a legal
  // looking count.
  assign win_sum   = {1'b0, edge_acc_q} + (ECW + 1)'(rise);
  assign win_total = (win_sum > ACC_MAX) ? {ECW{1'b1}} : win_sum[ECW-1:0];
  assign cnt_bad   = (win_sum != EXP_V);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    win_cnt_d  = win_cnt_q;
    edge_acc_d = edge_acc_q;
    good_cnt_d = good_cnt_q;
    win_bad_d  = win_bad_q;
    period_d   = period_q;
    edge_cnt_d = edge_cnt_q;
    per_err_d  = per_err_q;
    cnt_err_d  = cnt_err_q;
    period_vld = 1'b0;
    win_done   = 1'b0;
    timeout    = 1'b0;
    per_bad    = 1'b0;
    clean      = 1'b0;

    if (!bus.en) begin
      // Disabled: drop any partial window; sticky flags and results hold.
      state_d    = IDLE;
      per_cnt_d  = '0;
      win_cnt_d  = '0;
      edge_acc_d = '0;
      good_cnt_d = '0;
      win_bad_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;

        ARM: begin
          if (rise) begin
            // The arming rise is window cycle 0 and the first counted edge.
            state_d    = MEAS;
            per_cnt_d  = PW'(1);
            win_cnt_d  = WW'(1);
            edge_acc_d = ECW'(1);
            win_bad_d  = 1'b0;
          end else if (per_cnt_q == TO_V) begin
            timeout   = 1'b1;
            per_cnt_d = '0;
          end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + PW'(1);
          end
        end

        MEAS: begin
          if (rise) begin
            period_vld = 1'b1;
            period_d   = per_cnt_q;
            per_cnt_d  = PW'(1);
            per_bad    = (per_cnt_q < MIN_V) || (per_cnt_q > MAX_V);
            if (edge_acc_q != '1) edge_acc_d = edge_acc_q + ECW'(1);
          end else if (per_cnt_q == TO_V) begin
            timeout = 1'b1;
          end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + PW'(1);
          end

          if (timeout) begin
            // Stuck divider: abandon the window and wait for a fresh rise.
            state_d    = ARM;
            per_cnt_d  = '0;
            win_cnt_d  = '0;
            edge_acc_d = '0;
            win_bad_d  = 1'b0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_done   = 1'b1;
            edge_cnt_d = win_total;
            edge_acc_d = '0;
            win_cnt_d  = '0;
            win_bad_d  = 1'b0;
            clean      = !win_bad_q && !per_bad && !cnt_bad;
            if (!clean)                    good_cnt_d = '0;
            else if (good_cnt_q != LOCK_V) good_cnt_d = good_cnt_q + GW'(1);
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            if (per_bad) win_bad_d = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase

      if (timeout) good_cnt_d = '0;
      if (bus.clr) good_cnt_d = '0;

      // A new error wins over clr in the same cycle.
      per_err_d = per_bad || timeout || (per_err_q && !bus.clr);
      cnt_err_d = (win_done && cnt_bad) || (cnt_err_q && !bus.clr);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      win_cnt_q  <= '0;
      edge_acc_q <= '0;
      good_cnt_q <= '0;
      win_bad_q  <= 1'b0;
      period_q   <= '0;
      edge_cnt_q <= '0;
      per_err_q  <= 1'b0;
      cnt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      win_cnt_q  <= win_cnt_d;
      edge_acc_q <= edge_acc_d;
      good_cnt_q <= good_cnt_d;
      win_bad_q  <= win_bad_d;
      period_q   <= period_d;
      edge_cnt_q <= edge_cnt_d;
      per_err_q  <= per_err_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign bus.rise_pulse = rise;
  assign bus.period     = period_q;
  assign bus.period_vld = period_vld;
  assign bus.win_done   = win_done;
  assign bus.edge_cnt   = edge_cnt_q;
  assign bus.per_err    = per_err_q;
  assign bus.cnt_err    = cnt_err_q;
  assign bus.locked     = (good_cnt_q == LOCK_V);

endmodule
